moving_avg4: RTL and testbench
==============================

MOVING_AVG4 -- requirements
Module: moving_avg4

Interface
REQ-001 SHALL have parameter W, default 8, sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, window length, fixed at 4 (power of two; divide by shift of 2).
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port clr  input  1  synchronous window flush, same effect as reset.
REQ-006 SHALL have port in_valid  input  1  qualifies in_data for the current cycle.
REQ-007 SHALL have port in_data  input  W  unsigned sample.
REQ-008 SHALL have port out_valid  output  1  one-cycle pulse marking a new valid average.
REQ-009 SHALL have port avg  output  W  registered window mean, truncated.
REQ-010 SHALL have port sum  output  W+2  registered window sum.
REQ-011 SHALL have port fill  output  3  number of samples held, 0..4.

Function
REQ-012 SHALL keep a 4-deep window that advances only on edges where in_valid=1 and clr=0; it SHALL hold otherwise.
REQ-013 SHALL update sum on an accepted edge as sum + in_data - oldest, where oldest is the window's last stage before the shift; empty stages contribute 0.
REQ-014 SHALL compute sum at W+2 bits unsigned, with no overflow possible (max 4*(2^W-1)).
REQ-015 SHALL register avg as sum_next[W+1:2] on the same edge as sum, truncating and not rounding.
REQ-016 SHALL use an FSM with states FILL (fill<4) and RUN (fill=4); FILL moves to RUN on the 4th accepted sample, RUN stays in RUN, and clr or reset returns the FSM to FILL.
REQ-017 SHALL increment fill per accepted sample in FILL and saturate it at 4.
REQ-018 SHALL drive out_valid=1 for exactly the cycle after an accepted edge whose resulting fill=4, and SHALL drive it to 0 otherwise, including during FILL.
REQ-019 SHALL latch the result with 1 cycle of latency: a sample accepted at edge k appears in sum/avg/out_valid after edge k.
REQ-020 SHALL give clr priority over in_valid when both are asserted: the sample is discarded and the window empties.
REQ-021 SHALL hold sum, avg and fill during in_valid gaps, with out_valid=0.

Reset
REQ-022 SHALL set on reset: all window stages 0, sum=0, avg=0, fill=0, out_valid=0, FSM=FILL.
REQ-023 SHALL let reset override clr and in_valid, including when asserted mid-window; partial sums are discarded.
REQ-024 SHALL make clr produce the same register state as reset, one edge later than assertion.

Structure
REQ-025 SHALL place the FSM state encoding (FILL, RUN), DEPTH=4 and LOG2_DEPTH=2 in a shared package.
REQ-026 SHALL instantiate one sub-module, delay_line_en: a W-bit, 4-stage shift register with enable and synchronous reset/clear that exposes its last stage as oldest.
REQ-027 SHALL keep the arithmetic, fill counter and FSM in moving_avg4 itself.

Verification
REQ-028 SHALL cover: accept 10,20,30,40 on consecutive cycles -> out_valid first high after the 4th edge, sum=100, avg=25, fill=4.
REQ-029 SHALL cover: continue with 50 -> sum=140, avg=35; then 0 -> sum=120, avg=30.
REQ-030 SHALL cover: four samples of 255 -> sum=1020, avg=255, no wrap; then 0 -> sum=765, avg=191 (truncated).
REQ-031 SHALL cover: samples 8,8 then in_valid=0 for 5 cycles then 8,8 -> out_valid stays 0 through the gap, first pulse after the 4th sample with sum=32.
REQ-032 SHALL cover: clr and in_valid both high (data 99) while in RUN -> next cycle fill=0, sum=0, out_valid=0; 99 never appears in sum.
REQ-033 SHALL cover: reset asserted after 3 samples, then 4 samples of 4 -> first out_valid with sum=16, proving no stale window contents.

Source files
------------

// File: rtl/moving_avg4_pkg.sv
// Shared constants and FSM encoding for the 4-sample moving average.
package moving_avg4_pkg;

  localparam int DEPTH      = 4;
  localparam int LOG2_DEPTH = 2;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/moving_avg4_delay_line_en.sv
// Enabled shift register holding the sample window; the last stage is the
// sample that leaves the window on the next accepted shift.
module delay_line_en
  import moving_avg4_pkg::*;
#(
  parameter int W      = 8,
  parameter int STAGES = DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] oldest
);

  logic [W-1:0] stage [STAGES];

  // Shift in a new sample on enable; reset and clear empty every stage.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign oldest = stage[STAGES-1];

endmodule

// File: rtl/moving_avg4.sv
// Running mean of the last four accepted unsigned samples. The sum is kept
// incrementally (add newest, drop oldest) and the mean is the sum shifted
// right by two, truncated.
module moving_avg4
  import moving_avg4_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] avg,
  output logic [W+1:0] sum,
  output logic [2:0]   fill
);

  logic         accept;
  logic [W-1:0] oldest;
  logic [W+1:0] sum_next;
  state_t       state;
  state_t       state_next;
  logic [2:0]   fill_next;
  logic         full_next;

  // clr wins over in_valid: a sample presented with clr is discarded.
  assign accept = in_valid & ~clr;

  delay_line_en #(
    .W      (W),
    .STAGES (DEPTH)
  ) u_delay_line (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .en     (accept),
    .d      (in_data),
    .oldest (oldest)
  );

  // Empty stages hold zero, so the subtraction is exact while filling too.
  always_comb begin
    sum_next = sum + {2'b00, in_data} - {2'b00, oldest};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset || clr) state <= FILL;
    else              state <= state_next;
  end

  // FSM next state: leave FILL on the sample that completes the window.
  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (accept && fill == 3'(DEPTH - 1)) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = FILL;
    endcase
  end

  // FSM outputs: resulting fill count and whether the window is then full.
  always_comb begin
    fill_next = fill;
    full_next = 1'b0;
    if (accept) begin
      case (state)
        FILL:    fill_next = fill + 3'd1;
        RUN:     fill_next = 3'(DEPTH);
        default: fill_next = fill;
      endcase
      full_next = (fill_next == 3'(DEPTH));
    end
  end

  // Result registers: update on accepted samples, hold through gaps.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sum       <= '0;
      avg       <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      sum       <= sum_next;
      avg       <= sum_next[W+1:LOG2_DEPTH];
      fill      <= fill_next;
      out_valid <= full_next;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_moving_avg4.sv
// Bench for moving_avg4: queue-based window model compared every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_moving_avg4;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         clr;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic [W-1:0] avg;
  logic [W+1:0] sum;
  logic [2:0]   fill;

  int checks   = 0;
  int failures = 0;

  // model state
  int win[$];
  int exp_sum  = 0;
  int exp_avg  = 0;
  int exp_fill = 0;
  int exp_ov   = 0;
  bit model_live = 0;

  moving_avg4 #(.W(W), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .avg       (avg),
    .sum       (sum),
    .fill      (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d at t=%0t", name, got, want, $time);
    end
  endtask

  // Reference model: the window is simply the last four accepted samples.
  always @(posedge clk) begin
    if (reset || clr) begin
      win.delete();
      exp_ov = 0;
      if (reset) model_live = 1;
    end else if (in_valid) begin
      win.push_front(int'(in_data));
      if (win.size() > 4) void'(win.pop_back());
      exp_ov = (win.size() == 4) ? 1 : 0;
    end else begin
      exp_ov = 0;
    end
    exp_sum = 0;
    foreach (win[i]) exp_sum += win[i];
    exp_avg  = exp_sum / 4;
    exp_fill = win.size();
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      check("sum",       int'(sum),       exp_sum);
      check("avg",       int'(avg),       exp_avg);
      check("fill",      int'(fill),      exp_fill);
      check("out_valid", int'(out_valid), exp_ov);
    end
  end

  task automatic push(input int d);
    in_valid = 1'b1;
    in_data  = W'(d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string tag, input int s, input int a, input int f, input int ov);
    check({tag, ".sum"},       int'(sum),       s);
    check({tag, ".avg"},       int'(avg),       a);
    check({tag, ".fill"},      int'(fill),      f);
    check({tag, ".out_valid"}, int'(out_valid), ov);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    lit("reset", 0, 0, 0, 0);

    // basic fill
    push(10); push(20); push(30);
    lit("fill3", 60, 15, 3, 0);
    push(40);
    lit("first", 100, 25, 4, 1);
    push(50);
    lit("slide50", 140, 35, 4, 1);
    push(0);
    lit("slide0", 120, 30, 4, 1);

    // full-scale, no wrap, truncation
    repeat (4) push(255);
    lit("max", 1020, 255, 4, 1);
    push(0);
    lit("trunc", 765, 191, 4, 1);
    idle(1);
    lit("gap_hold", 765, 191, 4, 0);

    // clr beats in_valid while in RUN
    clr = 1'b1; in_valid = 1'b1; in_data = 8'd99;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    lit("clr", 0, 0, 0, 0);

    // gap during fill
    push(8); push(8);
    idle(5);
    lit("gap", 16, 4, 2, 0);
    push(8);
    lit("gap3", 24, 6, 3, 0);
    push(8);
    lit("gapfull", 32, 8, 4, 1);

    // reset mid-window discards partial contents
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    push(7); push(7); push(7);
    reset = 1'b1; in_valid = 1'b1; in_data = 8'd77;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    lit("midreset", 0, 0, 0, 0);
    push(4); push(4); push(4);
    lit("rst3", 12, 3, 3, 0);
    push(4);
    lit("rst4", 16, 4, 4, 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 63) == 0);
      clr      = ($urandom_range(0, 31) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = W'($urandom_range(0, 255));
      @(negedge clk);
    end
    reset = 1'b0; clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
